// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared constants and types for the multi-port register file
package reg_file_mp_pkg;

   localparam int RF_DEPTH_DEFAULT   = 4;
   localparam int RF_NWPORTS_DEFAULT = 2;
   localparam int RF_WIDTH_DEFAULT   = 32;

   typedef logic [RF_WIDTH_DEFAULT-1:0] rf_word_t;

endpackage

// File: rtl/reg_file_mp_rf_read_mux.sv
// rtl/reg_file_mp_rf_read_mux.sv - DEPTH:1 read mux, out-of-range select returns zero
module rf_read_mux #(
   parameter int DEPTH = 4,
   parameter int NSEL  = 2,
   parameter int WIDTH = 32
) (
   input  logic [DEPTH*WIDTH-1:0] data_i,
   input  logic [NSEL-1:0]        sel_i,
   output logic [WIDTH-1:0]       data_o
);

   always_comb begin
      data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (int'(sel_i) == k) begin
            data_o = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - N-write/N-read register file with shift mode, valid bits and optional bypass
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int REGFILE_DEPTH = RF_DEPTH_DEFAULT,
   parameter int REGFILE_NSEL  = $clog2(REGFILE_DEPTH),
   parameter int REGFILE_WIDTH = RF_WIDTH_DEFAULT,
   parameter int N_WPORTS      = RF_NWPORTS_DEFAULT,
   parameter int N_RPORTS      = 2,
   parameter int BYPASS        = 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                ce_i,
   input  logic                                clr_i,
   input  logic [N_WPORTS-1:0]                 we_i,
   input  logic [N_WPORTS*REGFILE_NSEL-1:0]    wsel_i,
   input  logic [N_WPORTS*REGFILE_WIDTH-1:0]   wdata_i,
   input  logic                                shift_i,
   input  logic [REGFILE_WIDTH-1:0]            shift_data_i,
   input  logic [N_RPORTS*REGFILE_NSEL-1:0]    rsel_i,
   output logic [N_RPORTS*REGFILE_WIDTH-1:0]   rdata_o,
   output logic [REGFILE_DEPTH*REGFILE_WIDTH-1:0] regs_o,
   output logic [REGFILE_DEPTH-1:0]            valid_o
);

   localparam int D = REGFILE_DEPTH;
   localparam int W = REGFILE_WIDTH;

   logic [D*W-1:0] mem_q, mem_d;
   logic [D-1:0]   valid_q, valid_d;
   logic [D*W-1:0] rd_src;

   // Shift first, then writes in ascending port order so the highest port wins.
   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      if (rst_i || clr_i) begin
         mem_d   = '0;
         valid_d = '0;
      end else if (ce_i) begin
         if (shift_i) begin
            mem_d   = {mem_q[(D-1)*W-1:0], shift_data_i};
            valid_d = {valid_q[D-2:0], 1'b1};
         end
         for (int p = 0; p < N_WPORTS; p++) begin
            for (int k = 0; k < D; k++) begin
               if (we_i[p] && int'(wsel_i[p*REGFILE_NSEL +: REGFILE_NSEL]) == k) begin
                  mem_d[k*W +: W] = wdata_i[p*W +: W];
                  valid_d[k]      = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q   <= '0;
         valid_q <= '0;
      end else begin
         mem_q   <= mem_d;
         valid_q <= valid_d;
      end
   end

   assign rd_src  = (BYPASS != 0) ? mem_d : mem_q;
   assign regs_o  = mem_q;
   assign valid_o = valid_q;

   for (genvar r = 0; r < N_RPORTS; r++) begin : g_rport
      rf_read_mux #(
         .DEPTH (D),
         .NSEL  (REGFILE_NSEL),
         .WIDTH (W)
      ) u_rf_read_mux (
         .data_i (rd_src),
         .sel_i  (rsel_i[r*REGFILE_NSEL +: REGFILE_NSEL]),
         .data_o (rdata_o[r*W +: W])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized and directed bench for reg_file_mp (depth 4 bypass, depth 5 registered)
module tb_reg_file_mp;
   import reg_file_mp_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic     rst [2];
   logic     ce [2];
   logic     clr [2];
   logic     shift [2];
   rf_word_t sdata [2];
   logic [1:0] we [2];
   logic [2:0] wsel [2][2];
   rf_word_t   wdata [2][2];
   logic [2:0] rsel [2][2];

   logic [63:0]  rd_a, rd_b;
   logic [127:0] regs_a;
   logic [159:0] regs_b;
   logic [3:0]   val_a;
   logic [4:0]   val_b;

   reg_file_mp #(.REGFILE_DEPTH(4), .BYPASS(1)) u_dut_a (
      .clk_i        (clk),
      .rst_i        (rst[0]),
      .ce_i         (ce[0]),
      .clr_i        (clr[0]),
      .we_i         (we[0]),
      .wsel_i       ({wsel[0][1][1:0], wsel[0][0][1:0]}),
      .wdata_i      ({wdata[0][1], wdata[0][0]}),
      .shift_i      (shift[0]),
      .shift_data_i (sdata[0]),
      .rsel_i       ({rsel[0][1][1:0], rsel[0][0][1:0]}),
      .rdata_o      (rd_a),
      .regs_o       (regs_a),
      .valid_o      (val_a)
   );

   reg_file_mp #(.REGFILE_DEPTH(5), .BYPASS(0)) u_dut_b (
      .clk_i        (clk),
      .rst_i        (rst[1]),
      .ce_i         (ce[1]),
      .clr_i        (clr[1]),
      .we_i         (we[1]),
      .wsel_i       ({wsel[1][1], wsel[1][0]}),
      .wdata_i      ({wdata[1][1], wdata[1][0]}),
      .shift_i      (shift[1]),
      .shift_data_i (sdata[1]),
      .rsel_i       ({rsel[1][1], rsel[1][0]}),
      .rdata_o      (rd_b),
      .regs_o       (regs_b),
      .valid_o      (val_b)
   );

   // Reference model: plain arrays of words and flags per instance.
   rf_word_t mem [2][5];
   rf_word_t nxt [2][5];
   logic     vm [2][5];
   logic     nv [2][5];
   int       depth [2]  = '{4, 5};
   int       bypass [2] = '{1, 0};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int addr_of(input int i, input logic [2:0] a);
      return (i == 0) ? int'(a[1:0]) : int'(a);
   endfunction

   function automatic logic [159:0] exp_regs(input int i);
      logic [159:0] e = '0;
      for (int k = 0; k < depth[i]; k++) e[k*32 +: 32] = mem[i][k];
      return e;
   endfunction

   function automatic logic [159:0] exp_valid(input int i);
      logic [159:0] e = '0;
      for (int k = 0; k < depth[i]; k++) e[k] = vm[i][k];
      return e;
   endfunction

   task automatic model_next(input int i);
      int a;
      for (int k = 0; k < 5; k++) begin
         nxt[i][k] = mem[i][k];
         nv[i][k]  = vm[i][k];
      end
      if (rst[i] || clr[i]) begin
         for (int k = 0; k < 5; k++) begin
            nxt[i][k] = '0;
            nv[i][k]  = 1'b0;
         end
      end else if (ce[i]) begin
         if (shift[i]) begin
            for (int k = depth[i] - 1; k >= 1; k--) begin
               nxt[i][k] = mem[i][k-1];
               nv[i][k]  = vm[i][k-1];
            end
            nxt[i][0] = sdata[i];
            nv[i][0]  = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            a = addr_of(i, wsel[i][p]);
            if (we[i][p] && a < depth[i]) begin
               nxt[i][a] = wdata[i][p];
               nv[i][a]  = 1'b1;
            end
         end
      end
   endtask

   task automatic settle_check();
      int       a;
      rf_word_t exp, obs;
      #1;
      for (int i = 0; i < 2; i++) begin
         model_next(i);
         for (int r = 0; r < 2; r++) begin
            a   = addr_of(i, rsel[i][r]);
            exp = (a >= depth[i]) ? '0 : (bypass[i] != 0) ? nxt[i][a] : mem[i][a];
            obs = (i == 0) ? rd_a[r*32 +: 32] : rd_b[r*32 +: 32];
            check($sformatf("rdata_%0d_%0d", i, r), {128'd0, obs}, {128'd0, exp});
         end
      end
   endtask

   task automatic edge_check();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 5; k++) begin
            mem[i][k] = nxt[i][k];
            vm[i][k]  = nv[i][k];
         end
      end
      @(negedge clk);
      check("regs_a", {32'd0, regs_a}, exp_regs(0));
      check("valid_a", {156'd0, val_a}, exp_valid(0));
      check("regs_b", regs_b, exp_regs(1));
      check("valid_b", {155'd0, val_b}, exp_valid(1));
   endtask

   task automatic tick();
      settle_check();
      edge_check();
   endtask

   task automatic idle(input int i);
      rst[i] = 1'b0; ce[i] = 1'b1; clr[i] = 1'b0; shift[i] = 1'b0; sdata[i] = '0;
      we[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin
         wsel[i][p] = '0; wdata[i][p] = '0; rsel[i][p] = '0;
      end
   endtask

   logic [159:0] snap;
   rf_word_t     old_b3;

   initial begin
      for (int i = 0; i < 2; i++) begin
         idle(i);
         for (int k = 0; k < 5; k++) begin
            mem[i][k] = '0; vm[i][k] = 1'b0;
         end
         rst[i] = 1'b1;
      end
      tick();
      check("init_regs_a", {32'd0, regs_a}, 160'd0);

      // Preload all entries with ones, then reset with writes and shift pending.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 2; i++) begin
            idle(i);
            we[i] = 2'b11;
            wsel[i][0] = 3'(2*c); wsel[i][1] = 3'(2*c + 1);
            wdata[i][0] = 32'hFFFF_FFFF; wdata[i][1] = 32'hFFFF_FFFF;
         end
         tick();
      end
      check("preload_a", {32'd0, regs_a}, {32'd0, {4{32'hFFFF_FFFF}}});
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; shift[i] = 1'b1; sdata[i] = 32'h1234_5678;
      end
      tick();
      check("rst_regs_a", {32'd0, regs_a}, 160'd0);
      check("rst_valid_a", {156'd0, val_a}, 160'd0);
      for (int i = 0; i < 2; i++) idle(i);
      settle_check();
      check("rst_rdata_a", {96'd0, rd_a}, 160'd0);
      edge_check();

      // Same-address collision: port 1 wins, visible through bypass.
      we[0] = 2'b11; wsel[0][0] = 3'd2; wsel[0][1] = 3'd2;
      wdata[0][0] = 32'h11; wdata[0][1] = 32'h22; rsel[0][0] = 3'd2;
      settle_check();
      check("coll_bypass", {128'd0, rd_a[31:0]}, 160'h22);
      edge_check();
      check("coll_reg", {128'd0, regs_a[95:64]}, 160'h22);
      check("coll_valid", {156'd0, val_a}, 160'b0100);

      // Shift plus write on the same cycle.
      idle(0);
      we[0] = 2'b11; wsel[0][0] = 3'd0; wsel[0][1] = 3'd1;
      wdata[0][0] = 32'hA; wdata[0][1] = 32'hB;
      tick();
      wsel[0][0] = 3'd2; wsel[0][1] = 3'd3;
      wdata[0][0] = 32'hC; wdata[0][1] = 32'hD;
      tick();
      idle(0);
      shift[0] = 1'b1; sdata[0] = 32'h99;
      we[0] = 2'b01; wsel[0][0] = 3'd1; wdata[0][0] = 32'h55;
      tick();
      check("shift_write", {32'd0, regs_a}, {32'd0, 32'hC, 32'hB, 32'h55, 32'h99});
      check("shift_valid0", {159'd0, val_a[0]}, 160'd1);

      // Clock-enable gating, then clear ignoring ce.
      snap = exp_regs(0);
      for (int c = 0; c < 3; c++) begin
         idle(0);
         ce[0] = 1'b0; shift[0] = 1'b1; sdata[0] = $urandom;
         we[0] = 2'b11; wsel[0][0] = 3'($urandom); wsel[0][1] = 3'($urandom);
         wdata[0][0] = $urandom; wdata[0][1] = $urandom;
         tick();
      end
      check("ce_hold", {32'd0, regs_a}, snap);
      idle(0);
      ce[0] = 1'b0; clr[0] = 1'b1;
      tick();
      check("clr_regs", {32'd0, regs_a}, 160'd0);
      check("clr_valid", {156'd0, val_a}, 160'd0);
      idle(0);

      // Depth 5: fill, then out-of-range write and read.
      for (int k = 0; k < 5; k++) begin
         idle(1);
         we[1] = 2'b01; wsel[1][0] = 3'(k); wdata[1][0] = 32'hB000 + 32'(k);
         tick();
      end
      idle(1);
      snap = exp_regs(1);
      we[1] = 2'b01; wsel[1][0] = 3'd6; wdata[1][0] = 32'h7; rsel[1][0] = 3'd7;
      settle_check();
      check("oor_rdata", {128'd0, rd_b[31:0]}, 160'd0);
      edge_check();
      check("oor_hold", regs_b, snap);

      // Registered read: old value this cycle, new value next cycle.
      idle(1);
      old_b3 = mem[1][3];
      we[1] = 2'b01; wsel[1][0] = 3'd3; wdata[1][0] = 32'hAB; rsel[1][0] = 3'd3;
      settle_check();
      check("nobyp_old", {128'd0, rd_b[31:0]}, {128'd0, old_b3});
      edge_check();
      idle(1);
      rsel[1][0] = 3'd3;
      settle_check();
      check("nobyp_new", {128'd0, rd_b[31:0]}, 160'hAB);
      edge_check();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            rst[i]   = ($urandom_range(0, 49) == 0);
            clr[i]   = ($urandom_range(0, 39) == 0);
            ce[i]    = ($urandom_range(0, 4) != 0);
            shift[i] = ($urandom_range(0, 2) == 0);
            sdata[i] = $urandom;
            we[i]    = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
               wsel[i][p]  = 3'($urandom);
               wdata[i][p] = $urandom;
               rsel[i][p]  = 3'($urandom);
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
